mc_ctrl_seq: RTL
================

Name: mc_ctrl_seq

Overview:
- Parametrised successor to the current multicycle control unit in the single-issue RV32I core.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction class and adds:
  - ready-based memory handshake with wait states and a timeout;
  - branch and JAL sequencing;
  - a sticky trap state;
  - cycle and retired-instruction counters for the LED probe mux.
- Sits between ID1 field outputs and the datapath enables/selects; drives IF, RegArray, ALU, DM.

Parameters:
- ALU_OP_W, 4, ALU operation code width.
- CNT_W, 32, width of cycle_cnt and instret_cnt.
- MEM_TO, 15, max wait cycles for mem_ready before a timeout trap (1..2^8-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  from ID1, stable from DECODE to end of instruction.
- funct3  in  3  from ID1.
- funct7  in  7  from ID1.
- zf  in  1  ALU zero flag, valid in EXEC.
- sf  in  1  ALU sign flag.
- of  in  1  ALU overflow flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request (instruction fetch or data).
- mem_we  out  1  data store strobe, qualified by mem_req.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = old_pc+imm (branch/JAL target).
- reg_write  out  1  RegArray write enable.
- alu_op  out  ALU_OP_W  ALU operation.
- alu_b_s  out  1  0 = rs2, 1 = imm32.
- w_data_s  out  2  0 = ALU F, 1 = imm32, 2 = MDR, 3 = PC+4 (link).
- state  out  3  current state, for the probe mux.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.
- cycle_cnt  out  CNT_W  cycles since reset, wraps.
- instret_cnt  out  CNT_W  retired instructions, wraps.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; trap = 0; trap_cause = 0; both counters = 0; wait counter = 0.
  - All strobes 0 while in reset and IDLE.
  - IDLE -> FETCH unconditionally on the first clock after reset release.
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 7.
- Output timing: outputs are combinational from state, opcode, funct3/funct7 and flags; state and counters are registered.
- FETCH:
  - mem_req = 1.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0, then -> DECODE. Otherwise stay in FETCH.
- DECODE:
  - 0110011 R-type, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch -> EXEC.
  - 0110111 LUI -> WB.
  - 1101111 JAL -> WB.
  - Any other opcode -> TRAP, cause 1.
- EXEC:
  - R-type: alu_op = {funct7[5], funct3}, alu_b_s = 0 -> WB.
  - I-ALU: alu_op = {funct3 == 101 ? funct7[5] : 0, funct3}, alu_b_s = 1 -> WB.
  - Load/store: alu_op = 0000 (add), alu_b_s = 1 -> MEM.
  - Branch: alu_op = 1000 (sub), alu_b_s = 0. Taken conditions:
    - BEQ (000): zf
    - BNE (001): !zf
    - BLT (100): sf ^ of
    - BGE (101): !(sf ^ of)
  - Taken branch: pc_write = 1, pc_src = 1. Either way -> FETCH, and the instruction retires.
  - Branch funct3 010/011/110/111 -> TRAP, cause 1; no pc_write.
- MEM:
  - mem_req = 1; mem_we = 1 for stores.
  - On mem_ready: load -> WB; store -> FETCH (retires).
- WB:
  - reg_write = 1; retires.
  - w_data_s: 0 for R-type and I-ALU, 1 for LUI, 2 for load, 3 for JAL.
  - JAL additionally drives pc_write = 1, pc_src = 1.
- Memory wait counter:
  - Counts consecutive FETCH/MEM cycles with mem_ready = 0; cleared on mem_ready or on state change.
  - Reaching MEM_TO -> TRAP, cause 2.
  - mem_ready in the same cycle the count reaches MEM_TO: ready wins, no trap.
- TRAP: all strobes 0; stays until reset; trap = 1; trap_cause holds the first cause.
- instret_cnt: +1 on each retiring transition (WB exit, store MEM exit, branch EXEC exit).
- cycle_cnt: +1 every cycle outside reset, including TRAP.
- Counter wrap: both counters wrap from 2^CNT_W - 1 to 0 with no flag.
- Reset asserted mid-instruction: immediate return to IDLE; no partial write is issued after the reset edge.

Decomposition:
- Package mc_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL;
  - state encodings;
  - ALU_ADD/ALU_SUB codes;
  - w_data_s and trap_cause enums.
- One sub-module, mc_branch_cmp: combinational funct3 + flags -> {taken, illegal}.

Test Plan:
- add x3,x1,x2 with mem_ready always 1 -> states 1,2,3,5,1; reg_write in the 4th cycle after reset release; instret_cnt = 1.
- lw with mem_ready held low 3 cycles in MEM -> stays in MEM for 4 cycles, then WB with w_data_s = 2; no trap.
- beq with zf = 1 -> pc_write with pc_src = 1 in EXEC; with zf = 0 -> no EXEC pc_write. Both retire: instret +1.
- Opcode 0001111 -> TRAP, trap_cause = 1; cycle_cnt keeps counting; instret_cnt frozen; all strobes 0.
- mem_ready low for MEM_TO = 15 cycles in FETCH -> TRAP, cause 2. Repeat with ready arriving on cycle 15 -> DECODE, no trap.
- rst_n pulsed low during MEM of a store -> state = 0 asynchronously, mem_we = 0, counters = 0; FETCH resumes one cycle after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control sequencer.
// Holds the RV32I opcode constants the sequencer decodes, the state
// encoding seen on the probe mux, ALU operation codes issued directly by
// the sequencer, and the write-back select / trap cause encodings.
package mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Encoding 6 is unused; TRAP sits at 7 so it stands out on the LEDs.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_IMM = 2'd1,
    WD_MDR = 2'd2,
    WD_PC4 = 2'd3
  } wdata_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_TIMEOUT = 2'd2
  } trap_cause_e;

  // Wide enough for any legal MEM_TO (1..255).
  localparam int WAIT_W = 8;

endpackage

// File: rtl/mc_branch_cmp.sv
// Branch condition evaluation.
// Ports:
//   funct3      - branch kind from the instruction
//   zf, sf, of  - ALU flags from the rs1 - rs2 subtraction
//   taken       - branch condition holds
//   illegal     - funct3 is not a supported branch kind
module mc_branch_cmp (
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  taken = zf;            // BEQ
      3'b001:  taken = !zf;           // BNE
      3'b100:  taken = sf ^ of;       // BLT: true sign of the difference
      3'b101:  taken = !(sf ^ of);    // BGE
      default: illegal = 1'b1;        // 010/011/110/111 raise an illegal-instruction trap
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multicycle control sequencer for the single-issue RV32I core.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction class, handshakes with
// memory through mem_ready with a wait-state timeout, and parks in a
// sticky TRAP state on illegal instructions or memory timeouts.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   opcode, funct3, funct7  - decoded instruction fields
//   zf, sf, of              - ALU flags, meaningful in EXEC
//   mem_ready               - memory completes the current request
//   mem_req, mem_we         - memory request / store strobe
//   ir_write, pc_write      - IR latch and PC update enables
//   pc_src                  - 0 = PC+4, 1 = branch/JAL target
//   reg_write               - register file write enable
//   alu_op, alu_b_s         - ALU operation and B operand select
//   w_data_s                - register write-back source select
//   state                   - current state for the probe mux
//   trap, trap_cause        - sticky trap flag and first cause
//   cycle_cnt, instret_cnt  - free-running cycle / retired counters
module mc_ctrl_seq
  import mc_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32,
  parameter int MEM_TO   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zf,
  input  logic                sf,
  input  logic                of,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_b_s,
  output logic [1:0]          w_data_s,
  output logic [2:0]          state,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt
);

  // The wait counter holds the number of low-ready cycles already seen,
  // so the cycle that would make it MEM_TO is the one that traps.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                trap_q, trap_d;
  trap_cause_e         cause_q, cause_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic                retire;
  wdata_e              wdata_sel;
  logic                br_taken, br_illegal;

  // Only funct7[5] selects between ALU variants.
  logic unused_f7;
  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  mc_branch_cmp u_branch_cmp (
    .funct3  (funct3),
    .zf      (zf),
    .sf      (sf),
    .of      (of),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    cause_d   = cause_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    alu_op    = '0;
    alu_b_s   = 1'b0;
    wdata_sel = WD_ALU;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
          OP_LUI, OP_JAL:                           state_d = S_WB;
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op  = ALU_OP_W'({funct7[5], funct3});
            state_d = S_WB;
          end
          OP_I: begin
            // Only shifts-right use funct7[5] (SRAI); for other I-ALU ops
            // those bits belong to the immediate.
            alu_op  = ALU_OP_W'({(funct3 == 3'b101) & funct7[5], funct3});
            alu_b_s = 1'b1;
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op  = ALU_OP_W'(ALU_ADD);
            alu_b_s = 1'b1;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            alu_op = ALU_OP_W'(ALU_SUB);
            if (br_illegal) begin
              state_d = S_TRAP;
              cause_d = TC_ILLEGAL;
            end else begin
              pc_write = br_taken;
              pc_src   = br_taken;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = TC_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (opcode)
          OP_LUI:  wdata_sel = WD_IMM;
          OP_LOAD: wdata_sel = WD_MDR;
          OP_JAL: begin
            wdata_sel = WD_PC4;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
          end
          default: wdata_sel = WD_ALU;
        endcase
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase

    trap_d    = trap_q | (state_d == S_TRAP);
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = instret_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TC_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign state       = state_q;
  assign w_data_s    = wdata_sel;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
